// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard/branch control path:
// forward-select encodings, branch-type codes and the scoreboard entry.
package pipe_pkg;

  localparam int TNEW_W = 2;

  // Forward-select encoding shared by both comparator operands.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_t;

  // Conditional-branch codes; 6 and 7 are reserved and never taken.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_t;

  // A source whose tuse equals this value is not read by the instruction.
  localparam logic [TNEW_W-1:0] TUSE_UNUSED = 2'd3;

  // One in-flight register write: destination and cycles until its result exists.
  typedef struct packed {
    logic              valid;
    logic [4:0]        dst;
    logic [TNEW_W-1:0] tnew;
  } sb_entry_t;

  // Advance an entry by one stage: the countdown drops by one and sticks at zero.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.tnew != '0) r.tnew = e.tnew - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-source hazard check: finds the youngest in-flight write to one source
// register and decides whether ID must stall and where to forward from.
module hazard_src_check
  import pipe_pkg::*;
(
  input  logic [4:0]        src,
  input  logic [TNEW_W-1:0] tuse,
  input  sb_entry_t         ent_e,
  input  sb_entry_t         ent_m,
  input  sb_entry_t         ent_w,
  output logic              stall_src,
  output fwd_sel_t          fwd_sel
);

  // Register 0 is hard-wired, so an entry targeting it never matches.
  function automatic logic is_match(input sb_entry_t e, input logic [4:0] s);
    return e.valid && (e.dst != 5'd0) && (e.dst == s);
  endfunction

  logic      found;
  sb_entry_t hit;
  fwd_sel_t  hit_stage;

  // Pick the youngest matching stage, then derive stall and forward select from it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    found     = 1'b0;
    hit       = '0;
    hit_stage = FWD_RF;
    if (is_match(ent_e, src)) begin
      found     = 1'b1;
      hit       = ent_e;
      hit_stage = FWD_E;
    end else if (is_match(ent_m, src)) begin
      found     = 1'b1;
      hit       = ent_m;
      hit_stage = FWD_M;
    end else if (is_match(ent_w, src)) begin
      found     = 1'b1;
      hit       = ent_w;
      hit_stage = FWD_W;
    end

    stall_src = found && (tuse != TUSE_UNUSED) && (hit.tnew > tuse);
    fwd_sel   = (found && hit.tnew == '0) ? hit_stage : FWD_RF;
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage scheduler for the branch comparator: tracks in-flight writes in
// E/M/W, stalls or forwards the ID sources, and resolves the branch condition.
module branch_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = TNEW_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          id_is_branch,
  input  logic [2:0]    id_br_type,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [TW-1:0] id_rs_tuse,
  input  logic [TW-1:0] id_rt_tuse,
  input  logic [4:0]    id_dst,
  input  logic [TW-1:0] id_tnew,
  input  logic [DW-1:0] rf_rs_data,
  input  logic [DW-1:0] rf_rt_data,
  input  logic [DW-1:0] fwd_e_data,
  input  logic [DW-1:0] fwd_m_data,
  input  logic [DW-1:0] fwd_w_data,
  output logic          stall,
  output logic [1:0]    fwd_sel_rs,
  output logic [1:0]    fwd_sel_rt,
  output logic [DW-1:0] cmp_a,
  output logic [DW-1:0] cmp_b,
  output logic          br_taken
);

  sb_entry_t ent_e, ent_m, ent_w;
  logic      stall_rs, stall_rt;
  fwd_sel_t  sel_rs, sel_rt;
  logic      cond;

  // Scoreboard shift: entries age toward W; a stalled or empty ID slot enters E as a bubble.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every entry shifts from its pre-edge value.
    if (reset) begin
      ent_e <= '0;
      ent_m <= '0;
      ent_w <= '0;
    end else begin
      ent_w <= sb_age(ent_m);
      ent_m <= sb_age(ent_e);
      if (!stall && id_valid) ent_e <= '{valid: 1'b1, dst: id_dst, tnew: id_tnew};
      else                    ent_e <= '0;
    end
  end

  hazard_src_check u_rs_check (
    .src       (id_rs),
    .tuse      (id_rs_tuse),
    .ent_e     (ent_e),
    .ent_m     (ent_m),
    .ent_w     (ent_w),
    .stall_src (stall_rs),
    .fwd_sel   (sel_rs)
  );

  hazard_src_check u_rt_check (
    .src       (id_rt),
    .tuse      (id_rt_tuse),
    .ent_e     (ent_e),
    .ent_m     (ent_m),
    .ent_w     (ent_w),
    .stall_src (stall_rt),
    .fwd_sel   (sel_rt)
  );

  assign stall      = (stall_rs | stall_rt) & id_valid;
  assign fwd_sel_rs = sel_rs;
  assign fwd_sel_rt = sel_rt;

  function automatic logic [DW-1:0] fwd_mux(input fwd_sel_t sel, input logic [DW-1:0] rf);
    case (sel)
      FWD_E:   return fwd_e_data;
      FWD_M:   return fwd_m_data;
      FWD_W:   return fwd_w_data;
      default: return rf;
    endcase
  endfunction

  assign cmp_a = fwd_mux(sel_rs, rf_rs_data);
  assign cmp_b = fwd_mux(sel_rt, rf_rt_data);

  // Branch condition; the zero-compare forms treat operand a as signed.
  always_comb begin
    cond = 1'b0;
    case (id_br_type)
      BR_BEQ:  cond = (cmp_a == cmp_b);
      BR_BNE:  cond = (cmp_a != cmp_b);
      BR_BLEZ: cond = ($signed(cmp_a) <= 0);
      BR_BGTZ: cond = ($signed(cmp_a) > 0);
      BR_BLTZ: cond = cmp_a[DW-1];
      BR_BGEZ: cond = ~cmp_a[DW-1];
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = id_valid & id_is_branch & ~stall & cond;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: each ID vector pushes its
// hand-computed response into a queue that a negedge monitor drains.
module tb_branch_hazard_ctrl;

  localparam int DW = 32;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_is_branch;
  logic [2:0]    id_br_type;
  logic [4:0]    id_rs, id_rt, id_dst;
  logic [TW-1:0] id_rs_tuse, id_rt_tuse, id_tnew;
  logic [DW-1:0] rf_rs_data, rf_rt_data, fwd_e_data, fwd_m_data, fwd_w_data;
  logic          stall, br_taken;
  logic [1:0]    fwd_sel_rs, fwd_sel_rt;
  logic [DW-1:0] cmp_a, cmp_b;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.DW(DW), .TW(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_is_branch (id_is_branch),
    .id_br_type   (id_br_type),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_tuse   (id_rs_tuse),
    .id_rt_tuse   (id_rt_tuse),
    .id_dst       (id_dst),
    .id_tnew      (id_tnew),
    .rf_rs_data   (rf_rs_data),
    .rf_rt_data   (rf_rt_data),
    .fwd_e_data   (fwd_e_data),
    .fwd_m_data   (fwd_m_data),
    .fwd_w_data   (fwd_w_data),
    .stall        (stall),
    .fwd_sel_rs   (fwd_sel_rs),
    .fwd_sel_rt   (fwd_sel_rt),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .br_taken     (br_taken)
  );

  typedef struct {
    int            id;
    logic          stall;
    logic [1:0]    fs_rs;
    logic [1:0]    fs_rt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          taken;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  task automatic check(input string name, input int id, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: the DUT outputs are combinational, so each queued vector is judged mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",      e.id, DW'(stall),      DW'(e.stall));
      check("fwd_sel_rs", e.id, DW'(fwd_sel_rs), DW'(e.fs_rs));
      check("fwd_sel_rt", e.id, DW'(fwd_sel_rt), DW'(e.fs_rt));
      check("cmp_a",      e.id, cmp_a,           e.a);
      check("cmp_b",      e.id, cmp_b,           e.b);
      check("br_taken",   e.id, DW'(br_taken),   DW'(e.taken));
    end
  end

  task automatic buses(input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d,
                       input logic [DW-1:0] e_d, input logic [DW-1:0] m_d,
                       input logic [DW-1:0] w_d);
    rf_rs_data = rs_d;
    rf_rt_data = rt_d;
    fwd_e_data = e_d;
    fwd_m_data = m_d;
    fwd_w_data = w_d;
  endtask

  // Drive one ID vector for one cycle and queue its expected response.
  task automatic step(input logic v, input logic br, input logic [2:0] bt,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [TW-1:0] rs_tu, input logic [TW-1:0] rt_tu,
                      input logic [4:0] dst, input logic [TW-1:0] tn,
                      input logic e_stall, input logic [1:0] e_fsrs, input logic [1:0] e_fsrt,
                      input logic [DW-1:0] e_a, input logic [DW-1:0] e_b, input logic e_taken);
    exp_t e;
    id_valid     = v;
    id_is_branch = br;
    id_br_type   = bt;
    id_rs        = rs;
    id_rt        = rt;
    id_rs_tuse   = rs_tu;
    id_rt_tuse   = rt_tu;
    id_dst       = dst;
    id_tnew      = tn;
    e = '{id: vec_id, stall: e_stall, fs_rs: e_fsrs, fs_rt: e_fsrt,
          a: e_a, b: e_b, taken: e_taken};
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] RS0 = 32'h11, RT0 = 32'h22, ED = 32'hE0, MD = 32'hA0, WD = 32'hB0;

  initial begin
    reset = 1'b1;
    buses(RS0, RT0, ED, MD, WD);
    step(0, 0, 3'd0, 0, 0, 3, 3, 0, 0, 0, 0, 0, RS0, RT0, 0);
    exp_q.delete();
    vec_id = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: empty scoreboard, operands straight from the register file.
    step(0, 0, 3'd0, 0, 0, 3, 3, 0, 0, 0, 0, 0, RS0, RT0, 0);
    // BEQ $0,$0 with zero RF data is taken.
    buses(0, 0, ED, MD, WD);
    step(1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Load $8 then BEQ $8,$9: two stall cycles, then forward from W.
    buses(RS0, RT0, ED, MD, WD);
    step(1, 0, 3'd0, 1, 2, 3, 3, 8, 2, 0, 0, 0, RS0, RT0, 0);
    buses(RS0, 5, ED, MD, 5);
    step(1, 1, 3'd0, 8, 9, 0, 0, 0, 0, 1, 0, 0, RS0, 5, 0);
    step(1, 1, 3'd0, 8, 9, 0, 0, 0, 0, 1, 0, 0, RS0, 5, 0);
    step(1, 1, 3'd0, 8, 9, 0, 0, 0, 0, 0, 3, 0, 5, 5, 1);

    // ALU $3 then BNE $3,$4: one stall, then forward from M; equal operands not taken.
    buses(RS0, RT0, ED, MD, WD);
    step(1, 0, 3'd0, 1, 2, 3, 3, 3, 1, 0, 0, 0, RS0, RT0, 0);
    buses(RS0, 7, ED, 7, WD);
    step(1, 1, 3'd1, 3, 4, 0, 0, 0, 0, 1, 0, 0, RS0, 7, 0);
    step(1, 1, 3'd1, 3, 4, 0, 0, 0, 0, 0, 2, 0, 7, 7, 0);

    // $5 written in E and W: youngest (E) wins; then sign-based branch forms.
    buses(RS0, RT0, ED, MD, WD);
    step(1, 0, 3'd0, 1, 2, 3, 3, 5, 0, 0, 0, 0, RS0, RT0, 0);
    step(1, 0, 3'd0, 1, 2, 3, 3, 0, 0, 0, 0, 0, RS0, RT0, 0);
    step(1, 0, 3'd0, 1, 2, 3, 3, 5, 0, 0, 0, 0, RS0, RT0, 0);
    buses(RS0, RT0, 32'h8000_0000, MD, WD);
    step(1, 1, 3'd3, 5, 0, 0, 3, 0, 0, 0, 1, 0, 32'h8000_0000, RT0, 0);
    buses(RS0, RT0, ED, 32'hFFFF_FFFF, WD);
    step(1, 1, 3'd4, 5, 0, 0, 3, 0, 0, 0, 2, 0, 32'hFFFF_FFFF, RT0, 1);
    buses(RS0, RT0, ED, MD, 5);
    step(1, 1, 3'd5, 5, 0, 0, 3, 0, 0, 0, 3, 0, 5, RT0, 1);
    buses(0, RT0, ED, MD, WD);
    step(1, 1, 3'd2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, RT0, 1);
    buses(0, 0, ED, MD, WD);
    step(1, 1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // tuse 1 against E tnew 1: no stall; next ID proves $7 entered E with tnew 1.
    buses(RS0, RT0, ED, MD, WD);
    step(1, 0, 3'd0, 1, 2, 3, 3, 6, 1, 0, 0, 0, RS0, RT0, 0);
    step(1, 0, 3'd0, 6, 2, 1, 3, 7, 1, 0, 0, 0, RS0, RT0, 0);
    step(1, 1, 3'd0, 7, 0, 0, 0, 0, 0, 1, 0, 0, RS0, RT0, 0);
    buses(RS0, 0, ED, 0, WD);
    step(1, 1, 3'd0, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);

    // Reset during a load-use stall clears the scoreboard at that edge.
    buses(RS0, RT0, ED, MD, WD);
    step(1, 0, 3'd0, 1, 2, 3, 3, 8, 2, 0, 0, 0, RS0, RT0, 0);
    reset = 1'b1;
    step(1, 1, 3'd0, 8, 9, 0, 0, 0, 0, 1, 0, 0, RS0, RT0, 0);
    reset = 1'b0;
    step(1, 1, 3'd0, 8, 9, 0, 0, 0, 0, 0, 0, 0, RS0, RT0, 0);

    // Invalid ID never stalls; rs == rt forwards identically on both sides.
    step(1, 0, 3'd0, 1, 2, 3, 3, 9, 2, 0, 0, 0, RS0, RT0, 0);
    step(0, 0, 3'd0, 9, 9, 0, 0, 0, 0, 0, 0, 0, RS0, RT0, 0);
    step(0, 0, 3'd0, 9, 9, 0, 0, 0, 0, 0, 0, 0, RS0, RT0, 0);
    buses(RS0, RT0, ED, MD, 32'h77);
    step(1, 1, 3'd0, 9, 9, 0, 0, 0, 0, 0, 3, 3, 32'h77, 32'h77, 1);

    id_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- ID-stage scheduler for the branch comparator path of the 5-stage MIPS pipeline.
- Keeps a 3-entry scoreboard of in-flight register writes (E, M, W) with Tnew countdowns.
- Decides stall vs. forward for the ID instruction's rs/rt.
- Selects the comparator operands and resolves branch taken for BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ.

Parameters:
- DW, 32, datapath width of operands and forward buses.
- TW, 2, width of Tnew/Tuse fields.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears scoreboard.
- id_valid  in  1  ID holds a real instruction.
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_br_type  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6–7 never taken.
- id_rs, id_rt  in  5 each  source register numbers.
- id_rs_tuse, id_rt_tuse  in  TW each  cycles until the source is needed; 3 = not used.
- id_dst  in  5  destination register; 0 = no write.
- id_tnew  in  TW  Tnew on entry to E (ALU 1, load 2, no result 0).
- rf_rs_data, rf_rt_data  in  DW each  register-file read data.
- fwd_e_data, fwd_m_data, fwd_w_data  in  DW each  forward buses from E/M/W pipeline registers.
- stall  out  1  freeze PC/IF/ID, insert bubble into E.
- fwd_sel_rs, fwd_sel_rt  out  2 each  0 RF, 1 E, 2 M, 3 W.
- cmp_a, cmp_b  out  DW each  selected operands to the comparator.
- br_taken  out  1  branch resolves taken this cycle.

Behaviour:
- Scoreboard entries E, M, W, each {valid, dst[4:0], tnew[TW-1:0]}.
- Reset: all valid=0, dst=0, tnew=0.
  - Immediately after reset: stall=0, fwd_sel=0, br_taken=0. cmp_a/cmp_b equal the RF data.
- Reset asserted mid-stall or mid-branch clears the scoreboard at that edge. Reset takes priority over all other updates.
- Per clock edge, not in reset:
  - W <= M, then M <= E, each with tnew decremented, saturating at 0.
  - If stall=0 and id_valid=1: E <= {1, id_dst, id_tnew}.
  - Otherwise: E <= bubble {0, 0, 0}.
- Match rule for a source s (rs or rt): the entry is valid, dst != 0, and dst == s.
  - Priority is youngest first: E, then M, then W.
  - Only the youngest matching entry is considered.
- Stall rule per used source (tuse != 3): stall if the youngest match has tnew > tuse.
  - stall = (rs stall OR rt stall) AND id_valid.
  - Register 0 never stalls or forwards.
- fwd_sel per source:
  - Points to the youngest match if its tnew == 0; else 0.
  - The operand is correct only for tuse=0 sources when stall=0; later stages re-forward tuse>0 sources.
- cmp_a/cmp_b: mux of RF/E/M/W data by fwd_sel_rs/fwd_sel_rt. Combinational, zero latency.
- br_taken = id_valid & id_is_branch & ~stall & cond. Operands are signed for the LEZ/GTZ/LTZ/GEZ cases.
  - BEQ: a == b.
  - BNE: a != b.
  - BLEZ: a <= 0.
  - BGTZ: a > 0.
  - BLTZ: a[DW-1].
  - BGEZ: ~a[DW-1].
- The delay slot is architectural; no flush output.
- Simultaneous events:
  - Matches in several stages resolve to the youngest.
  - rs == rt gives identical decisions on both sides.
  - A stall lasts until the countdown satisfies tuse. Max 2 cycles: load followed by a branch on its result.

Decomposition:
- Shared package pipe_pkg:
  - Forward-select encodings FWD_RF/E/M/W.
  - Branch-type codes.
  - Tuse "unused" constant (3).
  - Scoreboard entry typedef.
- Sub-module hazard_src_check, instantiated twice (rs, rt).
  - Inputs: one source number, its tuse, and the three entries.
  - Outputs: stall_src and fwd_sel.
- The comparator/condition logic stays inline.

Test Plan:
- Reset, then ID BEQ rs=rt=$0, rf data 0 → stall=0, br_taken=1, fwd_sel=0/0.
- Load to $8 (tnew 2), then BEQ $8,$9 (tuse 0) → stall=1 for 2 cycles. Third cycle: fwd_sel_rs=3 (W), stall=0. fwd_w_data=5, rt=5 gives br_taken=1.
- ALU to $3 (tnew 1), next cycle BNE $3,$4 → stall 1 cycle, then fwd_sel_rs=2 (M). fwd_m_data=7, rf_rt_data=7 gives br_taken=0.
- Writes to $5 in E (tnew 0) and W (tnew 0), ID BGTZ $5 → fwd_sel_rs=1 (E). fwd_e_data=0x80000000 gives br_taken=0 (negative).
- ALU instruction ID with rs tuse=1 matching E entry tnew=1 → stall=0, br_taken=0. Next ID entry is admitted to E with id_dst/id_tnew.
- Reset asserted during a load-use stall → next cycle scoreboard empty, stall=0, fwd_sel=0, cmp operands from RF.
